hash_msg_padder: RTL
====================

Name: hash_msg_padder

Overview:
- Upstream stage of the super hash processor. Accepts the raw message as a stream of 32-bit memory words and emits complete 512-bit padded blocks (16 words) ready for MD5, SHA-1 or SHA-256 compression.
- Performs byte-order conversion, 0x80 insertion, zero fill and 64-bit length append.
- The hash core then only iterates rounds over whole blocks.

Parameters:
- WORD_W, 32, input/output word width (fixed; present for documentation only).
- BLK_WORDS, 16, words per emitted block.

Ports:
- clk  in  1  single clock; all state on posedge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  pulse; begins a message when idle.
- opcode  in  2  00=MD5, 01=SHA-1, 10=SHA-256, 11=illegal.
- size  in  32  message length in bytes, sampled with start.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  padder accepts in_data this cycle.
- in_data  in  32  raw memory word, little-endian: byte 0 in [7:0].
- blk_valid  out  1  blk_data holds a full block.
- blk_ready  in  1  consumer takes the block.
- blk_data  out  512  word 0 in [511:480], word 15 in [31:0].
- blk_last  out  1  qualifies blk_data as the final block of the message.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse after the last block is accepted.

Behaviour:
- Reset is synchronous and active-high. Reset values: in_ready=0, blk_valid=0, blk_last=0, busy=0, done=0, blk_data=0; FSM to IDLE.
- Reset mid-operation discards the partial block and the remaining message. No done pulse is produced.
- IDLE:
  - start with opcode!=11 latches opcode and size, clears slot=0, word_idx=0, blk_cnt=0, nblocks=(size+8)/64+1; goes to FILL.
  - start with opcode==11 is ignored.
- start while busy is ignored.
- FILL: builds one slot s (0..15) per step. Global byte index of the slot is base=64*blk_cnt+4*s.
  - If base < size: slot needs data, so in_ready=1.
    - The slot advances only on in_valid&&in_ready.
    - Byte j (0..3) of the word is kept if base+j<size, replaced by 0x80 if base+j==size, otherwise 0.
  - If base >= size: in_ready=0 and the slot advances every cycle with no input consumed. Word=0x80 in byte 0 if base==size, else 0.
  - If blk_cnt==nblocks-1 and s>=14, length L={29'b0,size,3'b0} (64-bit bit count) overrides the slot.
    - SHA: s14=L[63:32], s15=L[31:0].
    - MD5: s14=L[31:0], s15=L[63:32].
  - Byte order:
    - SHA stores bytes big-endian: byte0 to [31:24], i.e. swap the raw word.
    - MD5 stores bytes little-endian: raw order, byte0 in [7:0].
  - The MD5 length words are stored without swapping.
  - After slot 15 is written, go to EMIT. Minimum FILL time is 16 cycles per block.
- EMIT:
  - blk_valid=1 and blk_last=(blk_cnt==nblocks-1).
  - blk_data and blk_last are held stable until blk_valid&&blk_ready. in_ready=0 throughout.
  - On handshake:
    - If not last: blk_cnt++, slot=0, back to FILL next cycle.
    - If last: go to IDLE; done=1 for exactly one cycle; busy drops the same cycle.
- blk_valid must not depend combinationally on blk_ready.
- in_ready depends only on registered state.
- Exactly ceil(size/4) input words are consumed per message. Extra input is never accepted.
- size=0 produces one block with the 0x80 byte in slot 0.
- If size%64 >= 56, the 0x80 byte lands in block n-2 and block n-1 carries zeros plus the length only.
- Counters are 32-bit. Byte-index compares use 33-bit arithmetic so there is no wrap near size=2^32-1 (such sizes are out of use, but there must be no X or overflow).

Decomposition:
- hash_pkg:
  - opcode enum HASH_MD5/HASH_SHA1/HASH_SHA256.
  - typedef blk_t (logic [15:0][31:0]).
  - BLK_BYTES=64, LEN_SLOT_HI/LO constants.
  - byte-swap function shared with the hash core.
- Sub-module pad_word_former (combinational): inputs raw word, base, size, opcode; output is the formatted slot word excluding the length override. It is unit-testable on its own.

Test Plan:
- SHA-1 "abc": size=3, in_data=0x00636261 → one block, w0=0x61626380, w1..w14=0, w15=0x00000018, blk_last=1, then done pulse; exactly 1 input handshake.
- MD5 "abc": size=3, same input → w0=0x80636261, w14=0x00000018, w15=0, blk_last=1.
- SHA-256 size=0 → no in_ready, one block: w0=0x80000000, w15=0, blk_last=1.
- SHA size=56 (14 words) → two blocks.
  - Block 0: w14=0x80000000, w15=0, blk_last=0.
  - Block 1: all zero except w15=0x000001C0, blk_last=1.
- SHA size=64 with in_valid toggling 1/0 and blk_ready held low 5 cycles at each EMIT:
  - 16 inputs are consumed.
  - blk_data is stable while stalled.
  - Block 1 has w0=0x80000000 and w15=0x00000200.
  - No input is accepted during EMIT.
- Reset asserted mid-FILL of block 0 (size=100) → next cycle blk_valid=0, busy=0, in_ready=0, no done. A new start then behaves as fresh.

Source files
------------

// File: rtl/hash_pkg.sv
// hash_pkg: shared types and helpers for the hash message padder and the
// downstream hash core.
//   hash_op_t  : algorithm select (MD5 / SHA-1 / SHA-256); 2'b11 is illegal.
//   blk_t      : one 512-bit block as 16 packed 32-bit words, word 0 in the MSBs.
//   BLK_BYTES  : bytes per block.
//   LEN_SLOT_HI/LO : slots carrying the 64-bit length (high word first, SHA order).
//   bswap32    : byte swap of a 32-bit word.
package hash_pkg;

    typedef enum logic [1:0] {
        HASH_MD5    = 2'b00,
        HASH_SHA1   = 2'b01,
        HASH_SHA256 = 2'b10
    } hash_op_t;

    localparam logic [1:0] HASH_OP_ILLEGAL = 2'b11;

    typedef logic [15:0][31:0] blk_t;

    localparam int unsigned BLK_BYTES   = 64;
    localparam logic [3:0]  LEN_SLOT_HI = 4'd14;
    localparam logic [3:0]  LEN_SLOT_LO = 4'd15;

    function automatic logic [31:0] bswap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/pad_word_former.sv
// pad_word_former: combinational formatting of one 32-bit block slot.
//   raw_word : little-endian memory word (byte 0 in [7:0])
//   base     : global byte index of the slot's byte 0 (33-bit, no wrap)
//   size     : message length in bytes
//   opcode   : algorithm; MD5 keeps little-endian order, SHA swaps to big-endian
//   word     : formatted slot (message bytes, 0x80 marker, zero fill);
//              the length override is applied by the caller.
module pad_word_former
    import hash_pkg::*;
(
    input  logic [31:0] raw_word,
    input  logic [32:0] base,
    input  logic [31:0] size,
    input  hash_op_t    opcode,
    output logic [31:0] word
);

    logic [32:0] size_x;
    logic [31:0] le_word;

    assign size_x = {1'b0, size};

    // Build the slot in memory (little-endian) order first, then reorder once.
    always_comb begin
        le_word = '0;
        for (int unsigned j = 0; j < 4; j++) begin
            if ((base + 33'(j)) < size_x) begin
                le_word[8*j +: 8] = raw_word[8*j +: 8];
            end else if ((base + 33'(j)) == size_x) begin
                le_word[8*j +: 8] = 8'h80;
            end
        end
    end

    assign word = (opcode == HASH_MD5) ? le_word : bswap32(le_word);

endmodule

// File: rtl/hash_msg_padder.sv
// hash_msg_padder: turns a raw message (stream of 32-bit little-endian memory
// words) into complete 512-bit padded blocks for MD5 / SHA-1 / SHA-256.
//   clk, reset          : single clock, synchronous active-high reset
//   start/opcode/size   : begin a message (opcode 11 ignored; ignored when busy)
//   in_valid/in_ready/in_data    : raw word input, exactly ceil(size/4) words taken
//   blk_valid/blk_ready/blk_data : padded block output, word 0 in [511:480]
//   blk_last            : qualifies the final block of the message
//   busy                : high from accepted start until done
//   done                : one-cycle pulse after the final block is accepted
module hash_msg_padder
    import hash_pkg::*;
#(
    parameter int unsigned WORD_W    = 32,
    parameter int unsigned BLK_WORDS = 16
)
(
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [1:0]                    opcode,
    input  logic [31:0]                   size,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [WORD_W-1:0]             in_data,
    output logic                          blk_valid,
    input  logic                          blk_ready,
    output logic [BLK_WORDS*WORD_W-1:0]   blk_data,
    output logic                          blk_last,
    output logic                          busy,
    output logic                          done
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_FILL = 2'd1;
    localparam logic [1:0] ST_EMIT = 2'd2;

    logic [1:0]  state_q;
    hash_op_t    op_q;
    logic [31:0] size_q;
    logic [3:0]  slot_q;
    logic [31:0] blk_cnt_q;
    logic [31:0] nblocks_q;
    blk_t        blk_q;
    logic        last_q;
    logic        done_q;

    logic [32:0] base;
    logic        need_data;
    logic        final_blk;
    logic        advance;
    logic [63:0] len_bits;
    logic [31:0] formed_word;
    logic [31:0] slot_word;

    // Byte index of the current slot, 33 bits wide so sizes near 2^32 do not wrap.
    assign base      = (33'(blk_cnt_q) << 6) + 33'({slot_q, 2'b00});
    assign need_data = base < {1'b0, size_q};
    assign final_blk = (blk_cnt_q == (nblocks_q - 32'd1));
    assign len_bits  = {29'b0, size_q, 3'b000};

    pad_word_former u_former (
        .raw_word (in_data),
        .base     (base),
        .size     (size_q),
        .opcode   (op_q),
        .word     (formed_word)
    );

    // Length override on the last two slots of the final block. MD5 stores the
    // low length word first and does not byte-swap it.
    always_comb begin
        slot_word = formed_word;
        if (final_blk && (slot_q >= LEN_SLOT_HI)) begin
            if (op_q == HASH_MD5) begin
                slot_word = (slot_q == LEN_SLOT_HI) ? len_bits[31:0] : len_bits[63:32];
            end else begin
                slot_word = (slot_q == LEN_SLOT_HI) ? len_bits[63:32] : len_bits[31:0];
            end
        end
    end

    // Data slots wait for an input handshake; padding slots advance every cycle.
    assign advance = (state_q == ST_FILL) && (!need_data || in_valid);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            op_q      <= HASH_MD5;
            size_q    <= '0;
            slot_q    <= '0;
            blk_cnt_q <= '0;
            nblocks_q <= '0;
            blk_q     <= '0;
            last_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start && (opcode != HASH_OP_ILLEGAL)) begin
                        op_q      <= hash_op_t'(opcode);
                        size_q    <= size;
                        slot_q    <= '0;
                        blk_cnt_q <= '0;
                        nblocks_q <= 32'(((33'(size) + 33'd8) >> 6) + 33'd1);
                        state_q   <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (advance) begin
                        blk_q[4'd15 - slot_q] <= slot_word;
                        slot_q <= slot_q + 4'd1;
                        if (slot_q == 4'd15) begin
                            last_q  <= final_blk;
                            state_q <= ST_EMIT;
                        end
                    end
                end
                ST_EMIT: begin
                    // slot_q has already wrapped to 0 for the next block.
                    if (blk_ready) begin
                        last_q <= 1'b0;
                        if (last_q) begin
                            done_q  <= 1'b1;
                            state_q <= ST_IDLE;
                        end else begin
                            blk_cnt_q <= blk_cnt_q + 32'd1;
                            state_q   <= ST_FILL;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == ST_FILL) && need_data;
    assign blk_valid = (state_q == ST_EMIT);
    assign blk_last  = last_q;
    assign blk_data  = blk_q;
    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;

endmodule
